axil_timer_slave: RTL and testbench

AXIL_TIMER_SLAVE -- requirements
Module: axil_timer_slave

---
 rtl/axil_timer_slave.sv | 201 ++++++++++++++++++++
 tb/tb_axil_timer_slave.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_timer_slave.sv
// AXI4-Lite slave wrapping a free-running 32-bit timer with compare match,
// level interrupt and a scratch register.
module axil_timer_slave #(
    parameter int          ADDR_WIDTH    = 16,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFFFFFF
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_N,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [31:0]           s_axil_wdata,
    input  logic [3:0]            s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [31:0]           s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic                  o_Irq
);

    localparam int IW = ADDR_WIDTH - 2;
    localparam logic [IW-1:0] A_CTRL    = IW'(0);
    localparam logic [IW-1:0] A_COUNT   = IW'(1);
    localparam logic [IW-1:0] A_COMPARE = IW'(2);
    localparam logic [IW-1:0] A_STATUS  = IW'(3);
    localparam logic [IW-1:0] A_SCRATCH = IW'(4);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic          r_ready_en;
    logic          r_aw_full;
    logic [IW-1:0] r_awidx;
    logic          r_w_full;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic          r_bvalid;
    logic [1:0]    r_bresp;
    logic          r_rvalid;
    logic [31:0]   r_rdata;
    logic [1:0]    r_rresp;

    logic [1:0]    r_ctrl;
    logic [31:0]   r_count;
    logic [31:0]   r_compare;
    logic          r_match;
    logic [31:0]   r_scratch;

    logic          w_awready;
    logic          w_wready;
    logic          w_arready;
    logic          w_wr_fire;
    logic          w_wr_mapped;
    logic [31:0]   w_wmask;
    logic          w_wr_ctrl;
    logic          w_wr_count;
    logic          w_wr_compare;
    logic          w_wr_status;
    logic          w_wr_scratch;
    logic [IW-1:0] w_rd_idx;
    logic [31:0]   w_rd_data;
    logic          w_rd_mapped;
    logic          w_rd_fire;
    logic          w_match_set;
    logic          w_match_clr;
    logic          w_unused;

    assign w_awready = r_ready_en & ~r_aw_full & ~r_bvalid;
    assign w_wready  = r_ready_en & ~r_w_full & ~r_bvalid;
    assign w_arready = r_ready_en & ~r_rvalid;

    assign s_axil_awready = w_awready;
    assign s_axil_wready  = w_wready;
    assign s_axil_arready = w_arready;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = r_rresp;
    assign o_Irq          = r_match & r_ctrl[1];

    // Byte lanes [1:0] never select a register.
    assign w_unused = &{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    assign w_wr_fire   = r_aw_full & r_w_full;
    assign w_wr_mapped = (r_awidx <= A_SCRATCH);
    assign w_wmask     = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}},
                          {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};

    assign w_wr_ctrl    = w_wr_fire & (r_awidx == A_CTRL);
    assign w_wr_count   = w_wr_fire & (r_awidx == A_COUNT);
    assign w_wr_compare = w_wr_fire & (r_awidx == A_COMPARE);
    assign w_wr_status  = w_wr_fire & (r_awidx == A_STATUS);
    assign w_wr_scratch = w_wr_fire & (r_awidx == A_SCRATCH);

    assign w_match_set = r_ctrl[0] & (r_count == r_compare);
    assign w_match_clr = w_wr_status & r_wstrb[0] & r_wdata[0];

    function automatic logic [31:0] f_merge(input logic [31:0] old,
                                            input logic [31:0] val,
                                            input logic [31:0] mask);
        return (old & ~mask) | (val & mask);
    endfunction

    assign w_rd_idx  = s_axil_araddr[ADDR_WIDTH-1:2];
    assign w_rd_fire = s_axil_arvalid & w_arready;

    always_comb begin
        w_rd_data   = 32'd0;
        w_rd_mapped = 1'b1;
        case (w_rd_idx)
            A_CTRL:    w_rd_data = {30'd0, r_ctrl};
            A_COUNT:   w_rd_data = r_count;
            A_COMPARE: w_rd_data = r_compare;
            A_STATUS:  w_rd_data = {31'd0, r_match};
            A_SCRATCH: w_rd_data = r_scratch;
            default:   w_rd_mapped = 1'b0;
        endcase
    end

    // Write channel: AW/W holding registers, single outstanding B beat.
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            r_ready_en <= 1'b0;
            r_aw_full  <= 1'b0;
            r_awidx    <= '0;
            r_w_full   <= 1'b0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'd0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
        end else begin
            r_ready_en <= 1'b1;
            if (s_axil_awvalid && w_awready) begin
                r_aw_full <= 1'b1;
                r_awidx   <= s_axil_awaddr[ADDR_WIDTH-1:2];
            end
            if (s_axil_wvalid && w_wready) begin
                r_w_full <= 1'b1;
                r_wdata  <= s_axil_wdata;
                r_wstrb  <= s_axil_wstrb;
            end
            if (w_wr_fire) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bvalid && s_axil_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_rresp  <= 2'b00;
        end else if (w_rd_fire) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_mapped ? RESP_OKAY : RESP_SLVERR;
        end else if (r_rvalid && s_axil_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // Register file; bus writes to COUNT override the increment.
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            r_ctrl    <= 2'd0;
            r_count   <= 32'd0;
            r_compare <= RESET_COMPARE;
            r_match   <= 1'b0;
            r_scratch <= 32'd0;
        end else begin
            if (w_wr_ctrl && r_wstrb[0])
                r_ctrl <= r_wdata[1:0];
            if (w_wr_count)
                r_count <= f_merge(r_count, r_wdata, w_wmask);
            else if (r_ctrl[0])
                r_count <= r_count + 32'd1;
            if (w_wr_compare)
                r_compare <= f_merge(r_compare, r_wdata, w_wmask);
            if (w_wr_scratch)
                r_scratch <= f_merge(r_scratch, r_wdata, w_wmask);
            if (w_match_set)
                r_match <= 1'b1;
            else if (w_match_clr)
                r_match <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_timer_slave.sv
// Scoreboard bench for axil_timer_slave: directed AXI-Lite traffic,
// expected B/R beats queued and checked by an independent monitor.
module tb_axil_timer_slave;

    localparam int AW = 16;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic          irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  q_b[$];
    logic [33:0] q_r[$];

    axil_timer_slave #(
        .ADDR_WIDTH(AW),
        .RESET_COMPARE(32'hFFFFFFFF)
    ) dut (
        .i_Clock(clk),
        .i_Reset_N(rst_n),
        .s_axil_awaddr(awaddr),
        .s_axil_awvalid(awvalid),
        .s_axil_awready(awready),
        .s_axil_wdata(wdata),
        .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid),
        .s_axil_wready(wready),
        .s_axil_bresp(bresp),
        .s_axil_bvalid(bvalid),
        .s_axil_bready(bready),
        .s_axil_araddr(araddr),
        .s_axil_arvalid(arvalid),
        .s_axil_arready(arready),
        .s_axil_rdata(rdata),
        .s_axil_rresp(rresp),
        .s_axil_rvalid(rvalid),
        .s_axil_rready(rready),
        .o_Irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // Monitor: pops an expectation whenever a response beat handshakes.
    always @(negedge clk) begin
        if (rst_n && bvalid && bready) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_extra: got bresp %b expected none", bresp);
            end else begin
                chk("bresp", 64'(bresp), 64'(q_b.pop_front()));
            end
        end
        if (rst_n && rvalid && rready) begin
            if (q_r.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL r_extra: got %h/%b expected none",
                         rdata, rresp);
            end else begin
                chk("rbeat", 64'({rdata, rresp}), 64'(q_r.pop_front()));
            end
        end
    end

    task automatic axi_write(input logic [AW-1:0] a,
                             input logic [31:0] d,
                             input logic [3:0] s,
                             input logic [1:0] er);
        bit aw_done = 0;
        bit w_done  = 0;
        bit ah;
        bit wh;
        int t = 0;
        q_b.push_back(er);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        while (!(aw_done && w_done)) begin
            ah = awvalid && awready;
            wh = wvalid && wready;
            @(posedge clk); #1;
            if (ah) begin awvalid = 1'b0; aw_done = 1; end
            if (wh) begin wvalid = 1'b0; w_done = 1; end
            if (++t > 50) begin
                timeout("write_accept");
                awvalid = 1'b0;
                wvalid  = 1'b0;
                return;
            end
        end
        t = 0;
        while (!bvalid) begin
            @(posedge clk); #1;
            if (++t > 50) begin timeout("write_resp"); return; end
        end
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [AW-1:0] a,
                            input logic [31:0] ed,
                            input logic [1:0] er);
        int t = 0;
        q_r.push_back({ed, er});
        araddr  = a;
        arvalid = 1'b1;
        while (!arready) begin
            @(posedge clk); #1;
            if (++t > 50) begin
                timeout("read_accept");
                arvalid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation ran too long");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_readies_low", 64'({awready, wready, arready}), 64'd0);
        chk("rst_valids", 64'({bvalid, rvalid, irq}), 64'd0);
        @(posedge clk); #1;
        chk("rst_readies_up", 64'({awready, wready, arready}), 64'h7);
        axi_read(16'h0000, 32'h0, 2'b00);
        axi_read(16'h0004, 32'h0, 2'b00);
        axi_read(16'h0008, 32'hFFFFFFFF, 2'b00);
        axi_read(16'h000B, 32'hFFFFFFFF, 2'b00);

        // Byte strobes over an all-ones scratch value.
        axi_write(16'h0010, 32'hFFFFFFFF, 4'hF, 2'b00);
        axi_write(16'h0010, 32'hA5A51234, 4'b0101, 2'b00);
        axi_read(16'h0010, 32'hFFA5FF34, 2'b00);

        // W three cycles ahead of AW, response back-pressured.
        bready = 1'b0;
        wdata  = 32'h11223344;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("w_held_ready", 64'({awready, wready}), 64'b10);
        awaddr  = 16'h0010;
        awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("both_held_ready", 64'({awready, wready, bvalid}), 64'b000);
        @(posedge clk); #1;
        q_b.push_back(2'b00);
        for (int i = 0; i < 5; i++) begin
            chk("bp_state", 64'({bvalid, awready, wready}), 64'b100);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        chk("b_single_beat", 64'(bvalid), 64'd0);
        axi_read(16'h0010, 32'h11223344, 2'b00);

        // Unmapped offset 0x14.
        axi_read(16'h0014, 32'h0, 2'b10);
        axi_write(16'h0014, 32'hDEADBEEF, 4'hF, 2'b10);
        axi_read(16'h0000, 32'h0, 2'b00);
        axi_read(16'h0004, 32'h0, 2'b00);
        axi_read(16'h0008, 32'hFFFFFFFF, 2'b00);
        axi_read(16'h000C, 32'h0, 2'b00);
        axi_read(16'h0010, 32'h11223344, 2'b00);

        // Compare match and interrupt timing.
        axi_write(16'h0008, 32'd5, 4'hF, 2'b00);
        axi_write(16'h0004, 32'd0, 4'hF, 2'b00);
        axi_write(16'h0000, 32'd3, 4'hF, 2'b00);
        for (int i = 0; i < 5; i++) begin
            chk("irq_early", 64'(irq), 64'd0);
            @(posedge clk); #1;
        end
        chk("irq_match", 64'(irq), 64'd1);
        axi_read(16'h000C, 32'd1, 2'b00);
        axi_write(16'h000C, 32'd1, 4'h1, 2'b00);
        chk("irq_cleared", 64'(irq), 64'd0);
        axi_read(16'h000C, 32'd0, 2'b00);

        // Counter wrap and write-over-increment.
        axi_write(16'h0000, 32'd0, 4'hF, 2'b00);
        axi_write(16'h0004, 32'hFFFFFFFE, 4'hF, 2'b00);
        axi_write(16'h0000, 32'd1, 4'hF, 2'b00);
        axi_read(16'h0004, 32'hFFFFFFFF, 2'b00);
        axi_read(16'h0004, 32'h00000001, 2'b00);
        axi_write(16'h0004, 32'h00000100, 4'hF, 2'b00);
        axi_read(16'h0004, 32'h00000101, 2'b00);
        axi_write(16'h0000, 32'd0, 4'hF, 2'b00);
        chk("irq_masked", 64'(irq), 64'd0);

        // Reset with both responses pending.
        axi_write(16'h0008, 32'h00001234, 4'hF, 2'b00);
        bready  = 1'b0;
        rready  = 1'b0;
        awaddr  = 16'h0010;
        wdata   = 32'h77;
        wstrb   = 4'hF;
        araddr  = 16'h0008;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        @(posedge clk); #1;
        chk("pending_both", 64'({bvalid, rvalid}), 64'b11);
        rst_n = 1'b0;
        #1;
        chk("rst_drop", 64'({bvalid, rvalid}), 64'b00);
        @(posedge clk); #1;
        bready = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rerst_ready", 64'({awready, wready, arready}), 64'h7);
        axi_read(16'h0008, 32'hFFFFFFFF, 2'b00);
        axi_read(16'h0010, 32'h0, 2'b00);
        axi_read(16'h0004, 32'h0, 2'b00);

        repeat (3) @(posedge clk);
        #1;
        chk("q_b_empty", 64'(q_b.size()), 64'd0);
        chk("q_r_empty", 64'(q_r.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
